// File: rtl/meas_pkg.sv
// meas_pkg: shared types and constants for the measurement discriminator path
package meas_pkg;
  localparam int ACC_W = 32;
  localparam int N_MEAS_DEF = 5;
  localparam int MEAS_LATENCY = 2;
  typedef logic signed [ACC_W-1:0] acc_t;
  function automatic int meas_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  localparam int MEAS_IDX_W = meas_idx_w(N_MEAS_DEF);
endpackage

// File: rtl/meas_sat_counter.sv
// meas_sat_counter: enabled up-counter that sticks at all-ones
module meas_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] count
);
  // count enabled events, holding once every bit is set
  always_ff @(posedge clk)
    if (!reset) count <= '0;
    else if (en && !(&count)) count <= count + 1'b1;
endmodule

// File: rtl/meas_discriminator.sv
// meas_discriminator: thresholds time-multiplexed readout samples into per-channel meas bits
module meas_discriminator import meas_pkg::*; #(
  parameter int N_MEAS    = 5,
  parameter int ACC_WIDTH = 32,
  parameter int CNT_WIDTH = 16,
  localparam int IW       = meas_idx_w(N_MEAS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic signed [ACC_WIDTH-1:0] acc_data,
  input  logic        [IW-1:0]        acc_chan,
  input  logic                        acc_valid,
  input  logic                        thresh_wr_en,
  input  logic        [IW-1:0]        thresh_wr_addr,
  input  logic signed [ACC_WIDTH-1:0] thresh_wr_data,
  input  logic        [IW-1:0]        cnt_rd_addr,
  output logic        [CNT_WIDTH-1:0] cnt_rd_data,
  output logic        [N_MEAS-1:0]    meas,
  output logic        [N_MEAS-1:0]    meas_valid,
  output logic                        chan_err
);
  localparam logic [IW:0] NM = (IW+1)'(N_MEAS);
  logic signed [ACC_WIDTH-1:0] thresh [N_MEAS];
  logic signed [ACC_WIDTH-1:0] data_s1, thr_s1, thr_rd;
  logic        [IW-1:0]        chan_s1;
  logic                        valid_s1, bit_s1;
  logic        [N_MEAS-1:0]    hit;
  logic        [CNT_WIDTH-1:0] cnt [N_MEAS];
  logic        [CNT_WIDTH-1:0] cnt_rd;
  assign bit_s1 = data_s1 >= thr_s1;
  // decode channel selects as plain muxes so out-of-range indices read zero and hit nothing
  always_comb begin
    thr_rd = '0;
    cnt_rd = '0;
    hit    = '0;
    for (int i = 0; i < N_MEAS; i++) begin
      thr_rd = (acc_chan == IW'(i)) ? thresh[i] : thr_rd;
      cnt_rd = (cnt_rd_addr == IW'(i)) ? cnt[i] : cnt_rd;
      hit[i] = valid_s1 && chan_s1 == IW'(i);
    end
  end
  // threshold register file; a write lands after the same-cycle sample has read the old value
  always_ff @(posedge clk)
    for (int i = 0; i < N_MEAS; i++)
      if (!reset) thresh[i] <= '0;
      else if (thresh_wr_en && thresh_wr_addr == IW'(i)) thresh[i] <= thresh_wr_data;
  // stage 1: capture the sample together with its channel threshold
  always_ff @(posedge clk)
    if (!reset) begin
      valid_s1 <= 1'b0;
      data_s1  <= '0;
      chan_s1  <= '0;
      thr_s1   <= '0;
    end else begin
      valid_s1 <= acc_valid;
      data_s1  <= acc_data;
      chan_s1  <= acc_chan;
      thr_s1   <= thr_rd;
    end
  // stage 2: publish the discriminated bit, flag bad channels, register counter readback
  always_ff @(posedge clk)
    if (!reset) begin
      meas        <= '0;
      meas_valid  <= '0;
      chan_err    <= 1'b0;
      cnt_rd_data <= '0;
    end else begin
      meas        <= (meas & ~hit) | (hit & {N_MEAS{bit_s1}});
      meas_valid  <= hit;
      chan_err    <= chan_err | (valid_s1 && {1'b0, chan_s1} >= NM);
      cnt_rd_data <= cnt_rd;
    end
  for (genvar c = 0; c < N_MEAS; c++) begin : g_cnt
    meas_sat_counter #(.W(CNT_WIDTH)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .en    (hit[c]),
      .count (cnt[c])
    );
  end
endmodule

// File: tb/tb_meas_discriminator.sv
// tb_meas_discriminator: directed and random checks against a transaction-level model
module tb_meas_discriminator;
  localparam int N = 5;
  localparam int CMAX = 15;
  logic        clk = 0, reset = 0;
  logic [31:0] acc_data = 0, thresh_wr_data = 0;
  logic [2:0]  acc_chan = 0, thresh_wr_addr = 0, cnt_rd_addr = 0;
  logic        acc_valid = 0, thresh_wr_en = 0;
  logic [3:0]  cnt_rd_data;
  logic [4:0]  meas, meas_valid;
  logic        chan_err;
  int n_chk = 0, n_pass = 0, cyc = 0;
  typedef struct { int due; int ch; bit b; } samp_t;
  samp_t q[$];
  samp_t s;
  int m_thr[N];
  int m_cnt[N];
  logic [4:0] e_meas = 0, e_mv = 0;
  logic       e_err = 0;
  logic [3:0] e_rd = 0;

  meas_discriminator #(.N_MEAS(5), .ACC_WIDTH(32), .CNT_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .acc_data(acc_data), .acc_chan(acc_chan), .acc_valid(acc_valid),
    .thresh_wr_en(thresh_wr_en), .thresh_wr_addr(thresh_wr_addr), .thresh_wr_data(thresh_wr_data),
    .cnt_rd_addr(cnt_rd_addr), .cnt_rd_data(cnt_rd_data), .meas(meas), .meas_valid(meas_valid),
    .chan_err(chan_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // model: each accepted sample becomes a result due one edge after capture, judged with the
  // threshold in force when it was presented; readback shows counts from before this edge
  always @(posedge clk) begin
    if (!reset) begin
      e_meas = 0; e_mv = 0; e_err = 0; e_rd = 0;
      q.delete();
      for (int i = 0; i < N; i++) begin m_thr[i] = 0; m_cnt[i] = 0; end
    end else begin
      e_rd = (cnt_rd_addr < 3'(N)) ? 4'(m_cnt[cnt_rd_addr]) : 4'd0;
      e_mv = 0;
      if (q.size() > 0 && q[0].due == cyc) begin
        s = q.pop_front();
        if (s.ch < N) begin
          e_meas[s.ch] = s.b;
          e_mv[s.ch] = 1'b1;
          if (m_cnt[s.ch] < CMAX) m_cnt[s.ch]++;
        end else e_err = 1'b1;
      end
      if (acc_valid)
        q.push_back('{cyc + 1, int'(acc_chan),
                      (acc_chan < 3'(N)) ? (int'($signed(acc_data)) >= m_thr[acc_chan]) : 1'b0});
      if (thresh_wr_en && thresh_wr_addr < 3'(N)) m_thr[thresh_wr_addr] = int'($signed(thresh_wr_data));
    end
    cyc++;
  end

  // compare every cycle, away from the active edge
  always @(negedge clk) begin
    chk("meas", 32'(meas), 32'(e_meas));
    chk("meas_valid", 32'(meas_valid), 32'(e_mv));
    chk("chan_err", 32'(chan_err), 32'(e_err));
    chk("cnt_rd_data", 32'(cnt_rd_data), 32'(e_rd));
  end

  task automatic step(input logic v, input logic [2:0] ch, input int d,
                      input logic we = 0, input logic [2:0] wa = 0, input int wd = 0);
    acc_valid = v; acc_chan = ch; acc_data = d;
    thresh_wr_en = we; thresh_wr_addr = wa; thresh_wr_data = wd;
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 0, 0);
  endtask

  initial begin
    reset = 0;
    cnt_rd_addr = 2;
    repeat (3) idle();
    chk("rst_meas", 32'(meas), 32'd0);
    chk("rst_valid", 32'(meas_valid), 32'd0);
    chk("rst_err", 32'(chan_err), 32'd0);
    chk("rst_rd", 32'(cnt_rd_data), 32'd0);
    reset = 1;
    step(0, 0, 0, 1, 2, 100);
    step(1, 2, 100);
    idle();
    chk("eq_valid", 32'(meas_valid), 32'(5'b00100));
    chk("eq_meas", 32'(meas), 32'(5'b00100));
    chk("mdl_eq_valid", 32'(e_mv), 32'(5'b00100));
    idle();
    chk("eq_pulse_end", 32'(meas_valid), 32'd0);
    chk("eq_cnt", 32'(cnt_rd_data), 32'd1);
    step(1, 2, 99);
    idle();
    chk("below_meas", 32'(meas), 32'd0);
    chk("below_valid", 32'(meas_valid), 32'(5'b00100));
    step(0, 0, 0, 1, 0, -10);
    step(1, 0, -5);
    idle();
    chk("neg_meas", 32'(meas), 32'(5'b00001));
    chk("neg_valid", 32'(meas_valid), 32'(5'b00001));
    idle();
    chk("hold_meas", 32'(meas), 32'(5'b00001));
    chk("hold_valid", 32'(meas_valid), 32'd0);
    step(1, 0, 20);
    step(1, 1, -1);
    chk("b2b0_valid", 32'(meas_valid), 32'(5'b00001));
    chk("b2b0_meas", 32'(meas), 32'(5'b00001));
    step(1, 0, -20);
    chk("b2b1_valid", 32'(meas_valid), 32'(5'b00010));
    chk("b2b1_meas", 32'(meas), 32'(5'b00001));
    step(1, 3, 7);
    chk("b2b2_valid", 32'(meas_valid), 32'(5'b00001));
    chk("b2b2_meas", 32'(meas), 32'(5'b00000));
    idle();
    chk("b2b3_valid", 32'(meas_valid), 32'(5'b01000));
    chk("b2b3_meas", 32'(meas), 32'(5'b01000));
    chk("mdl_b2b3", 32'(e_meas), 32'(5'b01000));
    idle();
    step(1, 1, 10, 1, 1, 50);
    idle();
    chk("coll_same_meas", 32'(meas), 32'(5'b01010));
    chk("coll_same_valid", 32'(meas_valid), 32'(5'b00010));
    step(1, 1, 10);
    idle();
    chk("coll_next_meas", 32'(meas), 32'(5'b01000));
    chk("mdl_coll_next", 32'(e_meas), 32'(5'b01000));
    step(0, 0, 0, 1, 6, 5);
    step(1, 5, 0);
    idle();
    chk("oob_valid", 32'(meas_valid), 32'd0);
    chk("oob_err", 32'(chan_err), 32'd1);
    chk("oob_meas", 32'(meas), 32'(5'b01000));
    repeat (3) idle();
    chk("oob_err_sticky", 32'(chan_err), 32'd1);
    cnt_rd_addr = 4;
    repeat (20) step(1, 4, int'($urandom_range(0, 100)) - 50);
    idle();
    idle();
    chk("sat_cnt", 32'(cnt_rd_data), 32'd15);
    chk("mdl_sat_cnt", 32'(e_rd), 32'd15);
    cnt_rd_addr = 7;
    idle();
    chk("oob_rd", 32'(cnt_rd_data), 32'd0);
    cnt_rd_addr = 2;
    step(1, 3, 5);
    reset = 0;
    idle();
    reset = 1;
    idle();
    chk("rst_mid_valid0", 32'(meas_valid), 32'd0);
    idle();
    chk("rst_mid_valid1", 32'(meas_valid), 32'd0);
    chk("rst_mid_err", 32'(chan_err), 32'd0);
    for (int a = 0; a < N; a++) begin
      cnt_rd_addr = 3'(a);
      idle();
      chk("rst_mid_cnt", 32'(cnt_rd_data), 32'd0);
    end
    step(1, 2, 50);
    idle();
    chk("rst_mid_thr", 32'(meas), 32'(5'b00100));
    for (int k = 0; k < 400; k++) begin
      reset = ($urandom_range(0, 99) != 0);
      cnt_rd_addr = 3'($urandom_range(0, 7));
      step($urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)), int'($urandom_range(0, 40)) - 20,
           $urandom_range(0, 4) == 0, 3'($urandom_range(0, 7)), int'($urandom_range(0, 40)) - 20);
    end
    reset = 1;
    repeat (3) idle();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
